// File: rtl/pair_packer_2w.sv
// pair_packer_2w
//   Collects single words from an upstream producer into ordered pairs for a
//   dual-write FIFO. One half slot holds the first word of a pair; one pair
//   register holds a completed pair until the FIFO accepts it. A flush request
//   turns a lone pending word into a pair padded with PAD_WORD.
//
// Ports
//   Clk             clock, all state changes on rising edge
//   Clear_in        asynchronous active-high reset
//   Data_in         upstream word (bit DATA_WIDTH-1 is the word-valid flag)
//   WriteEn_in      upstream word offered this cycle
//   Full_out        backpressure to upstream (accept = WriteEn_in & ~Full_out)
//   Flush_in        level request to pad out a pending half word
//   Data_out_1      older word of the held pair
//   Data_out_2      younger word of the held pair
//   WriteEn_out_2   pair held, offered to the FIFO
//   Full_in         FIFO full; pair drains when WriteEn_out_2 & ~Full_in
//   Idle_out        nothing held in the half slot or the pair register
//   Pair_count_out  pairs drained since reset, wraps
//
// Half-slot FSM
//   state    | meaning
//   ST_EMPTY | no pending half word
//   ST_HALF  | first word of the next pair is held in r_half_word

module pair_packer_2w #(
  parameter int                    DATA_WIDTH  = 65,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD    = '0,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Clear_in,
  input  logic [DATA_WIDTH-1:0]  Data_in,
  input  logic                   WriteEn_in,
  output logic                   Full_out,
  input  logic                   Flush_in,
  output logic [DATA_WIDTH-1:0]  Data_out_1,
  output logic [DATA_WIDTH-1:0]  Data_out_2,
  output logic                   WriteEn_out_2,
  input  logic                   Full_in,
  output logic                   Idle_out,
  output logic [COUNT_WIDTH-1:0] Pair_count_out
);

  typedef enum logic {ST_EMPTY, ST_HALF} state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_half_word;
  logic                   r_pair_valid;
  logic [DATA_WIDTH-1:0]  r_pair_w1;
  logic [DATA_WIDTH-1:0]  r_pair_w2;
  logic [COUNT_WIDTH-1:0] r_pair_count;

  state_t                 w_state_next;
  logic                   w_pair_valid_next;
  logic                   w_load_half;
  logic                   w_load_pair;
  logic [DATA_WIDTH-1:0]  w_pair_w2;
  logic                   w_accept;
  logic                   w_drain;
  logic                   w_pair_room;

  // Only a HALF state with a stuck pair can block; in EMPTY a word always
  // goes to the half slot, and in HALF with room the word completes a pair.
  assign Full_out       = (r_state == ST_HALF) & r_pair_valid & Full_in;
  assign WriteEn_out_2  = r_pair_valid;
  assign Data_out_1     = r_pair_w1;
  assign Data_out_2     = r_pair_w2;
  assign Idle_out       = (r_state == ST_EMPTY) & ~r_pair_valid;
  assign Pair_count_out = r_pair_count;

  assign w_accept    = WriteEn_in & ~Full_out;
  assign w_drain     = r_pair_valid & ~Full_in;
  // Pair register can take a new pair this edge: free, or emptying now.
  assign w_pair_room = ~r_pair_valid | ~Full_in;

  always_comb begin
    w_state_next      = r_state;
    w_pair_valid_next = r_pair_valid;
    w_load_half       = 1'b0;
    w_load_pair       = 1'b0;
    w_pair_w2         = PAD_WORD;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_half  = 1'b1;
          w_state_next = ST_HALF;
        end
      end
      ST_HALF: begin
        // An accepted word wins over flush; a held flush then sees EMPTY.
        if (w_accept) begin
          w_load_pair  = 1'b1;
          w_pair_w2    = Data_in;
          w_state_next = ST_EMPTY;
        end else if (Flush_in && w_pair_room) begin
          w_load_pair  = 1'b1;
          w_pair_w2    = PAD_WORD;
          w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
    // Reload takes precedence over drain so drain+form has no bubble.
    if (w_load_pair) begin
      w_pair_valid_next = 1'b1;
    end else if (w_drain) begin
      w_pair_valid_next = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      r_state      <= ST_EMPTY;
      r_pair_valid <= 1'b0;
      r_pair_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pair_valid <= w_pair_valid_next;
      if (w_drain) begin
        r_pair_count <= r_pair_count + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      r_half_word <= PAD_WORD;
      r_pair_w1   <= PAD_WORD;
      r_pair_w2   <= PAD_WORD;
    end else begin
      if (w_load_half) begin
        r_half_word <= Data_in;
      end
      if (w_load_pair) begin
        r_pair_w1 <= r_half_word;
        r_pair_w2 <= w_pair_w2;
      end
    end
  end

endmodule

// File: tb/tb_pair_packer_2w.sv
module tb_pair_packer_2w;

  localparam int DW = 65;
  localparam int CW = 16;

  logic          Clk;
  logic          Clear_in;
  logic [DW-1:0] Data_in;
  logic          WriteEn_in;
  logic          Full_out;
  logic          Flush_in;
  logic [DW-1:0] Data_out_1;
  logic [DW-1:0] Data_out_2;
  logic          WriteEn_out_2;
  logic          Full_in;
  logic          Idle_out;
  logic [CW-1:0] Pair_count_out;

  // Narrow-counter copy sharing all inputs: exercises counter wrap in a few
  // pairs instead of 2^16+1.
  logic          n_full;
  logic [DW-1:0] n_d1;
  logic [DW-1:0] n_d2;
  logic          n_we2;
  logic          n_idle;
  logic [3:0]    n_count;

  int checks = 0;
  int errors = 0;

  pair_packer_2w #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) u_dut (
    .Clk            (Clk),
    .Clear_in       (Clear_in),
    .Data_in        (Data_in),
    .WriteEn_in     (WriteEn_in),
    .Full_out       (Full_out),
    .Flush_in       (Flush_in),
    .Data_out_1     (Data_out_1),
    .Data_out_2     (Data_out_2),
    .WriteEn_out_2  (WriteEn_out_2),
    .Full_in        (Full_in),
    .Idle_out       (Idle_out),
    .Pair_count_out (Pair_count_out)
  );

  pair_packer_2w #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) u_dut_narrow (
    .Clk            (Clk),
    .Clear_in       (Clear_in),
    .Data_in        (Data_in),
    .WriteEn_in     (WriteEn_in),
    .Full_out       (n_full),
    .Flush_in       (Flush_in),
    .Data_out_1     (n_d1),
    .Data_out_2     (n_d2),
    .WriteEn_out_2  (n_we2),
    .Full_in        (Full_in),
    .Idle_out       (n_idle),
    .Pair_count_out (n_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Clear_in   = 1'b1;
    Data_in    = '0;
    WriteEn_in = 1'b0;
    Flush_in   = 1'b0;
    Full_in    = 1'b0;
    #3;
    chk_b("rst_we2", WriteEn_out_2, 1'b0);
    chk_b("rst_full", Full_out, 1'b0);
    chk_b("rst_idle", Idle_out, 1'b1);
    chk_w("rst_d1", Data_out_1, 65'h0);
    chk_w("rst_d2", Data_out_2, 65'h0);
    chk_c("rst_count", Pair_count_out, 16'd0);
    @(negedge Clk);
    Clear_in = 1'b0;

    // basic pair 0x1, 0x2
    WriteEn_in = 1'b1; Data_in = 65'h1;
    cyc();
    chk_b("p1_half_we2", WriteEn_out_2, 1'b0);
    chk_b("p1_half_idle", Idle_out, 1'b0);
    Data_in = 65'h2;
    cyc();
    chk_b("p1_we2", WriteEn_out_2, 1'b1);
    chk_w("p1_d1", Data_out_1, 65'h1);
    chk_w("p1_d2", Data_out_2, 65'h2);
    WriteEn_in = 1'b0;
    cyc();
    chk_b("p1_drained_we2", WriteEn_out_2, 1'b0);
    chk_c("p1_count", Pair_count_out, 16'd1);
    chk_b("p1_idle", Idle_out, 1'b1);

    // backpressure: {A,B} held, C in half, D stalls
    Full_in = 1'b1;
    WriteEn_in = 1'b1; Data_in = 65'hA;
    cyc();
    Data_in = 65'hB;
    cyc();
    chk_b("bp_we2", WriteEn_out_2, 1'b1);
    chk_b("bp_full_empty", Full_out, 1'b0);
    Data_in = 65'hC;
    cyc();
    chk_b("bp_full", Full_out, 1'b1);
    Data_in = 65'hD;
    cyc();
    chk_w("bp_hold_d1", Data_out_1, 65'hA);
    chk_w("bp_hold_d2", Data_out_2, 65'hB);
    cyc();
    chk_b("bp_still_full", Full_out, 1'b1);
    chk_c("bp_count_hold", Pair_count_out, 16'd1);
    Full_in = 1'b0;
    #1;
    chk_b("bp_full_comb", Full_out, 1'b0);
    cyc();
    chk_b("bp_nobubble_we2", WriteEn_out_2, 1'b1);
    chk_w("bp_cd_d1", Data_out_1, 65'hC);
    chk_w("bp_cd_d2", Data_out_2, 65'hD);
    chk_c("bp_count2", Pair_count_out, 16'd2);
    WriteEn_in = 1'b0;
    cyc();
    chk_b("bp_drain_we2", WriteEn_out_2, 1'b0);
    chk_c("bp_count3", Pair_count_out, 16'd3);

    // flush 0x5 with pad; held flush in EMPTY does nothing
    WriteEn_in = 1'b1; Data_in = 65'h5;
    cyc();
    WriteEn_in = 1'b0; Flush_in = 1'b1;
    cyc();
    chk_b("fl_we2", WriteEn_out_2, 1'b1);
    chk_w("fl_d1", Data_out_1, 65'h5);
    chk_w("fl_d2", Data_out_2, 65'h0);
    cyc();
    chk_b("fl_drain_we2", WriteEn_out_2, 1'b0);
    chk_c("fl_count", Pair_count_out, 16'd4);
    cyc();
    chk_b("fl_empty_we2", WriteEn_out_2, 1'b0);
    chk_b("fl_empty_idle", Idle_out, 1'b1);
    chk_c("fl_empty_count", Pair_count_out, 16'd4);
    Flush_in = 1'b0;

    // flush coinciding with second word: word wins
    WriteEn_in = 1'b1; Data_in = 65'h6;
    cyc();
    Data_in = 65'h7; Flush_in = 1'b1;
    cyc();
    chk_w("fw_d1", Data_out_1, 65'h6);
    chk_w("fw_d2", Data_out_2, 65'h7);
    WriteEn_in = 1'b0;
    cyc();
    chk_b("fw_nopad_we2", WriteEn_out_2, 1'b0);
    chk_c("fw_count", Pair_count_out, 16'd5);
    Flush_in = 1'b0;

    // async reset with half and pair held
    Full_in = 1'b1;
    WriteEn_in = 1'b1; Data_in = 65'h11;
    cyc();
    Data_in = 65'h12;
    cyc();
    Data_in = 65'h13;
    cyc();
    WriteEn_in = 1'b0;
    chk_b("ar_pre_full", Full_out, 1'b1);
    #2;
    Clear_in = 1'b1;
    #1;
    chk_b("ar_we2", WriteEn_out_2, 1'b0);
    chk_b("ar_full", Full_out, 1'b0);
    chk_b("ar_idle", Idle_out, 1'b1);
    chk_c("ar_count", Pair_count_out, 16'd0);
    chk_w("ar_d1", Data_out_1, 65'h0);
    chk_w("ar_d2", Data_out_2, 65'h0);
    @(negedge Clk);
    Clear_in = 1'b0; Full_in = 1'b0;
    WriteEn_in = 1'b1; Data_in = 65'h9;
    cyc();
    chk_b("ar_half_we2", WriteEn_out_2, 1'b0);
    Data_in = 65'hA;
    cyc();
    chk_w("ar_d1_new", Data_out_1, 65'h9);
    chk_w("ar_d2_new", Data_out_2, 65'hA);
    chk_c("ar_count_new", Pair_count_out, 16'd0);

    // streaming order plus counter wrap on the narrow instance
    for (int i = 0; i < 16; i++) begin
      Data_in = DW'(32'h100 + 2 * i);
      cyc();
      Data_in = DW'(32'h101 + 2 * i);
      cyc();
      chk_w($sformatf("st_d1_%0d", i), Data_out_1, DW'(32'h100 + 2 * i));
      chk_w($sformatf("st_d2_%0d", i), Data_out_2, DW'(32'h101 + 2 * i));
    end
    WriteEn_in = 1'b0;
    cyc();
    chk_c("st_count", Pair_count_out, 16'd17);
    chk_c("wrap_count", {12'd0, n_count}, 16'd1);
    chk_b("st_idle", Idle_out, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pair_packer_2w.md
PAIR_PACKER_2W -- requirements
Module: pair_packer_2w

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 65, the width of one word; bit DATA_WIDTH-1 is the word-valid flag.
REQ-002 SHALL have parameter PAD_WORD, default all-zeros, the filler word used in flush pairs.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, the width of the pair counter.
REQ-004 Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Clear_in  input  1  reset, asynchronous and active-high.
REQ-006 Data_in  input  DATA_WIDTH  upstream word.
REQ-007 WriteEn_in  input  1  upstream word offered this cycle.
REQ-008 Full_out  output  1  backpressure to upstream; a word is accepted only when WriteEn_in & ~Full_out.
REQ-009 Flush_in  input  1  level request to emit a pending single word padded with PAD_WORD.
REQ-010 Data_out_1  output  DATA_WIDTH  older word of the pair, to the dual-write FIFO Data_in_1.
REQ-011 Data_out_2  output  DATA_WIDTH  younger word of the pair, to FIFO Data_in_2.
REQ-012 WriteEn_out_2  output  1  pair present, to FIFO WriteEn_in_2.
REQ-013 Full_in  input  1  FIFO Full_out; a pair drains in any cycle with WriteEn_out_2 & ~Full_in.
REQ-014 Idle_out  output  1  no half word and no pair held.
REQ-015 Pair_count_out  output  COUNT_WIDTH  number of pairs drained since reset.

Function
REQ-016 SHALL hold one half slot (half_valid plus word) and one pair register (pair_valid plus two words); state = {EMPTY, HALF} × {pair free, pair held}.
REQ-017 Accepted word in EMPTY: SHALL load the half slot and go to HALF; outputs unchanged.
REQ-018 Accepted word in HALF: SHALL load the pair register with {half word, Data_in} and go to EMPTY, provided the pair register is free or drains that cycle.
REQ-019 Latency: the second word of a pair accepted at edge N SHALL give WriteEn_out_2=1 from just after edge N.
REQ-020 WriteEn_out_2 SHALL equal pair_valid (registered); Data_out_1/2 SHALL be stable while pair_valid & Full_in.
REQ-021 Full_out SHALL = half_valid & pair_valid & Full_in (combinational in Full_in); it never blocks in EMPTY.
REQ-022 Drain without reload: pair_valid SHALL clear at the edge.
REQ-023 Simultaneous drain and pair formation: the pair register SHALL reload at the same edge with no bubble.
REQ-024 Flush: when Flush_in=1, half_valid=1, no word is accepted that cycle, and the pair register is free or draining, SHALL load {half word, PAD_WORD} and go to EMPTY.
REQ-025 Flush with EMPTY SHALL have no effect; an accepted word SHALL take priority over flush in the same cycle, and a flush that is still held then applies to the new state.
REQ-026 Pair_count_out SHALL increment by 1 per drain and wrap modulo 2^COUNT_WIDTH.
REQ-027 Word order SHALL be preserved: acceptance order equals Data_out_1-then-Data_out_2 order across pairs.
REQ-028 Idle_out SHALL = ~half_valid & ~pair_valid.

Reset
REQ-029 Clear_in=1 SHALL immediately clear half_valid, pair_valid and Pair_count_out, giving WriteEn_out_2=0, Full_out=0, Idle_out=1, with Data_out_1/2 = PAD_WORD.
REQ-030 Reset mid-operation SHALL discard the held half word and pair without draining them; the first accepted word after release starts a new pair.

Verification
REQ-031 Words 0x1, 0x2 on consecutive cycles with Full_in=0 -> one cycle with WriteEn_out_2=1, Data_out_1=0x1, Data_out_2=0x2; Pair_count_out=1.
REQ-032 Full_in=1, send 0xA, 0xB, 0xC -> the pair {0xA,0xB} holds stable, Full_out=1 once 0xC is in the half slot and further words stall; release Full_in -> {0xA,0xB} drains, and {0xC, next word} follows with no bubble.
REQ-033 Send 0x5, then Flush_in=1 -> pair {0x5, PAD_WORD} is emitted; flush held in EMPTY -> no further pair.
REQ-034 Flush_in=1 in the same cycle as accepting the second word 0x7 after 0x6 -> pair {0x6,0x7}, with no pad pair emitted.
REQ-035 Assert Clear_in asynchronously while in HALF with a pair held -> outputs reset within the same cycle; 0x9, 0xA after release -> pair {0x9,0xA}.
REQ-036 Drain 2^16+1 pairs -> Pair_count_out=1.
